// File: rtl/vga_frame_streamer.sv
// vga_frame_streamer
// ------------------
// Producer side of the VGA driver pixel-load interface. A single-cycle `go`
// command captures a base address and a destination buffer index. The block
// then reads IMG_W*IMG_H pixels from image memory, which has a 1-cycle read
// latency, and streams them one per cycle into the selected VGA frame buffer.
//
// Ports
//   clk, rst_n           system clock (rising edge), asynchronous active-low reset
//   go, img_sel          frame command and destination buffer index (sampled with go)
//   base_addr            memory address of pixel 0 (sampled with go)
//   hold                 pause request; blocks new memory reads in the same cycle
//   mem_re, mem_addr     image memory read port
//   mem_rdata            read data, valid the cycle after mem_re
//   start, img_idx       frame-start pulse and buffer index to the VGA driver
//   we, wdata            pixel write strobe and data to the VGA driver
//   busy, done           busy from START to the last we; done pulses once afterwards
module vga_frame_streamer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              img_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              start,
  output logic              img_idx,
  output logic              we,
  output logic [PIX_W-1:0]  wdata,
  output logic              busy,
  output logic              done
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // address of the next read
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;   // reads issued this frame
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;   // we pulses issued this frame
  logic                rvalid_q;             // mem_rdata carries a pixel this cycle
  logic                we_q, we_d;
  logic [PIX_W-1:0]    wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                img_idx_q, img_idx_d;
  logic                rd_en;

  // hold gates the read in the cycle it is asserted. The rest of the read
  // decision comes from registered state, so mem_re only sees hold
  // combinationally.
  assign rd_en = ((state_q == S_START) || (state_q == S_STREAM))
                 && !hold && (rd_cnt_q != N_C);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    img_idx_d = img_idx_q;
    // Write pipeline: data returned for a read becomes a we one cycle later.
    we_d      = rvalid_q;
    wdata_d   = rvalid_q ? mem_rdata : wdata_q;

    if (rd_en) begin
      addr_d   = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (rvalid_q) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          img_idx_d = img_sel;
          addr_d    = base_addr;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          start_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_START;
        end
      end
      S_START, S_STREAM: begin
        state_d = (rd_cnt_d == N_C) ? S_DRAIN : S_STREAM;
      end
      S_DRAIN: begin
        // wr_cnt_q reaches N in the cycle that carries the last we.
        if (wr_cnt_q == N_C) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;   // go is ignored here; it is accepted from the next cycle
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rvalid_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      img_idx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rvalid_q  <= rd_en;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      img_idx_q <= img_idx_d;
    end
  end

  assign mem_re   = rd_en;
  assign mem_addr = addr_q;
  assign start    = start_q;
  assign img_idx  = img_idx_q;
  assign we       = we_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Testbench for vga_frame_streamer (4x2 frame).
// The main instance uses an 8-bit address space and the memory image
// mem[a] = a + 0x100. A second instance with ADDR_W=4 checks address
// wrap-around. Expected addresses and pixels are pushed into scoreboard
// queues when go is driven. They are popped and compared whenever the DUT
// shows mem_re or we. Control outputs are checked cycle by cycle against
// per-test bit masks.
module tb_vga_frame_streamer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int N     = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0, img_sel = 1'b0, hold = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        mem_re, start, img_idx, we, busy, done;
  logic [7:0]  mem_addr;
  logic [11:0] mem_rdata = '0, wdata;

  logic        go_w = 1'b0, img_sel_w = 1'b0, hold_w = 1'b0;
  logic [3:0]  base_addr_w = '0;
  logic        mem_re_w, start_w, img_idx_w, we_w, busy_w, done_w;
  logic [3:0]  mem_addr_w;
  logic [11:0] mem_rdata_w = '0, wdata_w;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [7:0]  addr_q_sb[$];
  logic [11:0] data_q_sb[$];

  always #5 clk = ~clk;

  vga_frame_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(8), .PIX_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .img_sel(img_sel), .base_addr(base_addr),
    .hold(hold), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .start(start), .img_idx(img_idx), .we(we), .wdata(wdata), .busy(busy), .done(done)
  );

  vga_frame_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(4), .PIX_W(12)) dut_w (
    .clk(clk), .rst_n(rst_n), .go(go_w), .img_sel(img_sel_w), .base_addr(base_addr_w),
    .hold(hold_w), .mem_re(mem_re_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .start(start_w), .img_idx(img_idx_w), .we(we_w), .wdata(wdata_w), .busy(busy_w), .done(done_w)
  );

  // Image memories with a 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_re)   mem_rdata   <= 12'h100 + {4'h0, mem_addr};
    if (mem_re_w) mem_rdata_w <= 12'h200 + {8'h0, mem_addr_w};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock, drive this cycle's inputs, then settle to the sample point.
  task automatic step(input logic g, input logic s, input logic [7:0] b, input logic h);
    @(posedge clk);
    #1;
    go = g; img_sel = s; base_addr = b; hold = h;
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      addr_q_sb.push_back(b + 8'(i));
      data_q_sb.push_back(12'h100 + {4'h0, b + 8'(i)});
    end
  endtask

  task automatic sb_check(input int c);
    if (mem_re) begin
      if (addr_q_sb.size() == 0) chk($sformatf("extra_read_c%0d", c), 32'(mem_addr), 32'hFFFF);
      else chk($sformatf("mem_addr_c%0d", c), 32'(mem_addr), 32'(addr_q_sb.pop_front()));
    end
    if (we) begin
      if (data_q_sb.size() == 0) chk($sformatf("extra_we_c%0d", c), 32'(wdata), 32'hFFFF);
      else chk($sformatf("wdata_c%0d", c), 32'(wdata), 32'(data_q_sb.pop_front()));
    end
  endtask

  // Runs one frame: go in cycle 0, then cycles 1..17. Extra go pulses with the
  // opposite img_sel and another base are driven in cycles g2a and g2b; all of
  // them must be ignored.
  task automatic run_frame(input string nm, input logic [7:0] b, input logic sel,
                           input logic [31:0] hold_m, input logic [31:0] re_m,
                           input logic [31:0] we_m, input logic [31:0] busy_m,
                           input int done_c, input int g2a, input int g2b);
    addr_q_sb.delete();
    data_q_sb.delete();
    push_frame(b);
    for (int c = 0; c < 18; c++) begin
      if (c == 0)                   step(1'b1, sel, b, hold_m[c]);
      else if (c == g2a || c == g2b) step(1'b1, ~sel, 8'h40, hold_m[c]);
      else                          step(1'b0, 1'b0, 8'h00, hold_m[c]);
      chk($sformatf("%s_start_c%0d", nm, c), 32'(start), 32'(c == 1));
      chk($sformatf("%s_re_c%0d", nm, c),    32'(mem_re), 32'(re_m[c]));
      chk($sformatf("%s_we_c%0d", nm, c),    32'(we), 32'(we_m[c]));
      chk($sformatf("%s_busy_c%0d", nm, c),  32'(busy), 32'(busy_m[c]));
      chk($sformatf("%s_done_c%0d", nm, c),  32'(done), 32'(c == done_c));
      if (c >= 1) chk($sformatf("%s_idx_c%0d", nm, c), 32'(img_idx), 32'(sel));
      sb_check(c);
    end
    chk({nm, "_reads_left"}, 32'(addr_q_sb.size()), 32'd0);
    chk({nm, "_pix_left"},   32'(data_q_sb.size()), 32'd0);
    $display("frame %s base=%0h sel=%0d done_cycle=%0d", nm, b, sel, done_c);
  endtask

  initial begin
    logic [3:0] wrap_exp;
    int         we_cnt_w;
    int         done_cnt_w;

    #2;
    chk("reset_outputs", 32'({mem_re, mem_addr, start, img_idx, we, wdata, busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame, with a go during busy (cycle 5) and on the done cycle (11).
    run_frame("basic", 8'h10, 1'b1, 32'h0, 32'h01FE, 32'h07F8, 32'h07FE, 11, 5, 11);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Hold in cycles 4..6.
    run_frame("hold", 8'h10, 1'b1, 32'h0070, 32'h0F8E, 32'h3E38, 32'h3FFE, 14, -1, -1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // Hold during the START cycle suppresses only the first read.
    run_frame("holdstart", 8'h30, 1'b0, 32'h0002, 32'h03FC, 32'h0FF0, 32'h0FFE, 12, -1, -1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a frame.
    step(1'b1, 1'b1, 8'h20, 1'b0);
    for (int c = 1; c < 6; c++) step(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({mem_re, mem_addr, start, img_idx, we, wdata, busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk($sformatf("postreset_done_c%0d", c), 32'({done, busy, we, mem_re}), 32'd0);
    end
    $display("reset mid-frame: outputs cleared, no done");
    run_frame("afterreset", 8'h10, 1'b1, 32'h0, 32'h01FE, 32'h07F8, 32'h07FE, 11, -1, -1);

    // Address wrap on the 4-bit instance.
    wrap_exp   = 4'hE;
    we_cnt_w   = 0;
    done_cnt_w = 0;
    @(posedge clk);
    #1 go_w = 1'b1; img_sel_w = 1'b1; base_addr_w = 4'hE;
    for (int c = 1; c < 16; c++) begin
      @(posedge clk);
      #1 go_w = 1'b0;
      #1;
      if (mem_re_w) begin
        chk($sformatf("wrap_addr_c%0d", c), 32'(mem_addr_w), 32'(wrap_exp));
        wrap_exp = wrap_exp + 4'd1;
      end
      if (we_w) we_cnt_w++;
      if (done_w) done_cnt_w++;
    end
    chk("wrap_last_addr_next", 32'(wrap_exp), 32'h6);
    chk("wrap_we_count", 32'(we_cnt_w), 32'(N));
    chk("wrap_done_count", 32'(done_cnt_w), 32'd1);
    chk("wrap_last_wdata", 32'(wdata_w), 32'h205);
    $display("wrap frame base=E reads=%0d writes=%0d", N, we_cnt_w);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
